// File: rtl/bht_port_scheduler.sv
// Single-port BHT arbiter: fetch lookups share the port with queued read-modify-write updates.
// Optional power-on sweep of INIT_VAL into every entry is compiled in with BHT_INIT_SWEEP_EN.
module bht_port_scheduler #(
  parameter int         IDX_W    = 4,
  parameter int         QDEPTH   = 4,
  parameter logic [1:0] INIT_VAL = 2'b01
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pred_req,
  input  logic [IDX_W-1:0]           pred_idx,
  output logic                       pred_gnt,
  output logic                       pred_valid,
  output logic                       pred_taken,
  input  logic                       upd_valid,
  input  logic [IDX_W-1:0]           upd_idx,
  input  logic                       upd_taken,
  output logic                       upd_ready,
  output logic                       bht_en,
  output logic                       bht_we,
  output logic [IDX_W-1:0]           bht_idx,
  output logic [1:0]                 bht_wdata,
  input  logic [1:0]                 bht_rdata,
  output logic [$clog2(QDEPTH):0]    q_count,
  output logic                       init_done,
  output logic [1:0]                 fsm_state
);
  localparam int QW = $clog2(QDEPTH);
  localparam int CW = QW + 1;

  typedef enum logic [1:0] {INIT, IDLE, UPD_RD, UPD_WR} state_t;

  state_t           state;
  logic             init_done_r;
  logic             pv;
  logic [QW-1:0]    head, tail;
  logic [CW-1:0]    count;
  logic [IDX_W-1:0] q_idx [QDEPTH];
  logic             q_tk  [QDEPTH];
  logic             full, empty, push, pop;
`ifdef BHT_INIT_SWEEP_EN
  logic [IDX_W-1:0] init_idx;
`endif

  function automatic logic [1:0] sat_next(input logic [1:0] v, input logic tk);
    if (tk) return (v == 2'b11) ? v : v + 2'b01;
    else    return (v == 2'b00) ? v : v - 2'b01;
  endfunction

  // Handshakes: a transfer happens on a clock edge where valid and ready are both high;
  // the offerer holds valid and payload stable until that edge.
  assign full       = (count == CW'(QDEPTH));
  assign empty      = (count == '0);
  assign upd_ready  = init_done_r && !full;
  assign push       = upd_valid && upd_ready;
  assign pred_gnt   = !reset && (state == IDLE) && pred_req && !full;
  assign pop        = !reset && (state == UPD_RD);
  assign pred_valid = pv;
  assign pred_taken = pv & bht_rdata[1];
  assign q_count    = count;
  assign init_done  = init_done_r;
  assign fsm_state  = state;

  // Port drive is combinational so a granted read returns data on the very next cycle.
  always_comb begin
    bht_en    = 1'b0;
    bht_we    = 1'b0;
    bht_idx   = '0;
    bht_wdata = '0;
    if (!reset) begin
      case (state)
`ifdef BHT_INIT_SWEEP_EN
        INIT: begin
          bht_en    = 1'b1;
          bht_we    = 1'b1;
          bht_idx   = init_idx;
          bht_wdata = INIT_VAL;
        end
`endif
        IDLE: begin
          if (pred_gnt) begin
            bht_en  = 1'b1;
            bht_idx = pred_idx;
          end else if (!empty) begin
            bht_en  = 1'b1;
            bht_idx = q_idx[head];
          end
        end
        UPD_RD: begin
          bht_en    = 1'b1;
          bht_we    = 1'b1;
          bht_idx   = q_idx[head];
          bht_wdata = sat_next(bht_rdata, q_tk[head]);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_idx[tail] <= upd_idx;
      q_tk[tail]  <= upd_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      pv    <= 1'b0;
`ifdef BHT_INIT_SWEEP_EN
      state       <= INIT;
      init_idx    <= '0;
      init_done_r <= 1'b0;
`else
      state       <= IDLE;
      init_done_r <= 1'b1;
`endif
    end else begin
      pv <= pred_gnt;
      if (push) tail <= tail + QW'(1);
      if (pop)  head <= head + QW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      case (state)
`ifdef BHT_INIT_SWEEP_EN
        INIT: begin
          init_idx <= init_idx + IDX_W'(1);
          if (&init_idx) begin
            state       <= IDLE;
            init_done_r <= 1'b1;
          end
        end
`endif
        IDLE:    if (!pred_gnt && !empty) state <= UPD_RD;
        UPD_RD:  state <= UPD_WR;
        UPD_WR:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
